// File: rtl/mips_core_pkg.sv
// Shared core definitions used by the load value predictor: FSM states,
// table entry layout for the default configuration and small helpers.
package mips_core_pkg;

  localparam int VP_ADDR_WIDTH  = 32;
  localparam int VP_DATA_WIDTH  = 32;
  localparam int VP_ENTRIES     = 64;
  localparam int VP_CONF_BITS   = 2;
  localparam int VP_CONF_THRESH = 3;
  localparam int VP_DEPTH       = 4;
  localparam int VP_IDX_W       = $clog2(VP_ENTRIES);
  localparam int VP_TAG_W       = VP_ADDR_WIDTH - VP_IDX_W - 2;

  typedef enum logic {
    VP_NORMAL,
    VP_RECOVER
  } vp_state_e;

  typedef struct packed {
    logic                     valid;
    logic [VP_TAG_W-1:0]      tag;
    logic [VP_DATA_WIDTH-1:0] value;
    logic [VP_CONF_BITS-1:0]  conf;
  } vp_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

`ifdef LVP_STATS_EN
`ifdef SIMULATION
  function automatic void stats_event(input string name, input logic [31:0] count);
    $display("[stats] %s %0d", name, count);
  endfunction
`endif
`endif

endpackage

// File: rtl/load_value_predictor_if.sv
// Lookup / resolve / recovery bus between the pipeline (master) and the
// load value predictor (slave).
interface load_value_predictor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  lookup_valid;
  logic [ADDR_WIDTH-1:0] lookup_pc;
  logic                  pred_valid;
  logic [DATA_WIDTH-1:0] pred_value;
  logic                  res_valid;
  logic [ADDR_WIDTH-1:0] res_pc;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_predicted;
  logic                  flush;
  logic                  mispredict;
  logic                  recover_req;
  logic                  recovery_done;
  logic                  overflow_err;

  modport master (
    output lookup_valid, lookup_pc, res_valid, res_pc, res_data,
           res_predicted, flush, recovery_done,
    input  pred_valid, pred_value, mispredict, recover_req, overflow_err
  );

  modport slave (
    input  lookup_valid, lookup_pc, res_valid, res_pc, res_data,
           res_predicted, flush, recovery_done,
    output pred_valid, pred_value, mispredict, recover_req, overflow_err
  );
endinterface

// File: rtl/vp_inflight_fifo.sv
// In-order queue of issued predictions awaiting their D-cache result.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module vp_inflight_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign wr_idx  = IDX_W'(wr_ptr & PTR_W'(DEPTH - 1));
  assign rd_idx  = IDX_W'(rd_ptr & PTR_W'(DEPTH - 1));
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr - rd_ptr) == PTR_W'(DEPTH));
  assign head    = mem[rd_idx];
  // A push into a full queue is legal when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/load_value_predictor.sv
// Last-value load predictor with confidence gating, in-order misprediction
// checking and a recovery handshake. Optional counters: LVP_STATS_EN.
module load_value_predictor
  import mips_core_pkg::*;
#(
  parameter int ADDR_WIDTH  = VP_ADDR_WIDTH,
  parameter int DATA_WIDTH  = VP_DATA_WIDTH,
  parameter int ENTRIES     = VP_ENTRIES,
  parameter int CONF_BITS   = VP_CONF_BITS,
  parameter int CONF_THRESH = VP_CONF_THRESH,
  parameter int DEPTH       = VP_DEPTH
) (
  input logic                   clk,
  input logic                   rst,
  load_value_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam logic [CONF_BITS-1:0] CONF_MAX       = '1;
  localparam logic [CONF_BITS-1:0] CONF_MIN_ISSUE = CONF_BITS'(CONF_THRESH);

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] value;
    logic [CONF_BITS-1:0]  conf;
  } row_t;

  row_t                  vp_table [ENTRIES];
  vp_state_e             state;

  logic [IDX_W-1:0]      lk_idx;
  logic [IDX_W-1:0]      rs_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [TAG_W-1:0]      rs_tag;
  row_t                  lk_row;
  row_t                  rs_row;
  logic                  lk_hit;
  logic                  rs_hit;
  logic                  issue;
  logic                  pop_req;
  logic                  do_pop;
  logic                  empty_resolve;
  logic                  value_bad;
  logic                  go_recover;
  logic                  fifo_clear;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  unused_pc_bits;

  logic                  pred_valid_q;
  logic [DATA_WIDTH-1:0] pred_value_q;
  logic                  mispredict_q;
  logic                  recover_req_q;
  logic                  overflow_err_q;

  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag = bus.lookup_pc[ADDR_WIDTH-1:IDX_W+2];
  assign rs_idx = bus.res_pc[IDX_W+1:2];
  assign rs_tag = bus.res_pc[ADDR_WIDTH-1:IDX_W+2];
  assign lk_row = vp_table[lk_idx];
  assign rs_row = vp_table[rs_idx];
  assign lk_hit = lk_row.valid && (lk_row.tag == lk_tag);
  assign rs_hit = rs_row.valid && (rs_row.tag == rs_tag);
  assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.res_pc[1:0]};

  // A flushed resolve still trains the table but never checks the queue.
  assign pop_req       = bus.res_valid && bus.res_predicted && !bus.flush;
  assign do_pop        = pop_req && !fifo_empty;
  assign empty_resolve = pop_req && fifo_empty;
  assign value_bad     = do_pop && (fifo_head != bus.res_data);
  assign go_recover    = value_bad && (state == VP_NORMAL);
  assign fifo_clear    = bus.flush || go_recover;

  assign issue = bus.lookup_valid && lk_hit && (lk_row.conf >= CONF_MIN_ISSUE) &&
                 (!fifo_full || do_pop) && (state == VP_NORMAL) && !bus.flush;

  vp_inflight_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (lk_row.value),
    .pop       (do_pop),
    .clear     (fifo_clear),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Lookups read the table combinationally, so they see the pre-update row.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) vp_table[i] <= '0;
    end else if (bus.res_valid) begin
      if (rs_hit && (rs_row.value == bus.res_data)) begin
        vp_table[rs_idx].conf <= (rs_row.conf == CONF_MAX) ? rs_row.conf
                                                           : rs_row.conf + 1'b1;
      end else begin
        vp_table[rs_idx] <= '{valid: 1'b1, tag: rs_tag, value: bus.res_data, conf: '0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= VP_NORMAL;
      pred_valid_q   <= 1'b0;
      pred_value_q   <= '0;
      mispredict_q   <= 1'b0;
      recover_req_q  <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      pred_valid_q <= issue;
      pred_value_q <= issue ? lk_row.value : '0;
      mispredict_q <= go_recover;
      if (empty_resolve) overflow_err_q <= 1'b1;
      case (state)
        VP_NORMAL: begin
          if (go_recover) begin
            state         <= VP_RECOVER;
            recover_req_q <= 1'b1;
          end
        end
        VP_RECOVER: begin
          if (bus.recovery_done) begin
            state         <= VP_NORMAL;
            recover_req_q <= 1'b0;
          end
        end
        default: begin
          state         <= VP_NORMAL;
          recover_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_value   = pred_value_q;
  assign bus.mispredict   = mispredict_q;
  assign bus.recover_req  = recover_req_q;
  assign bus.overflow_err = overflow_err_q;

`ifdef LVP_STATS_EN
  logic [31:0] stat_lookup;
  logic [31:0] stat_issue;
  logic [31:0] stat_correct;
  logic [31:0] stat_mispredict;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookup     <= '0;
      stat_issue      <= '0;
      stat_correct    <= '0;
      stat_mispredict <= '0;
    end else begin
      if (bus.lookup_valid)     stat_lookup     <= sat_inc32(stat_lookup);
      if (issue)                stat_issue      <= sat_inc32(stat_issue);
      if (do_pop && !value_bad) stat_correct    <= sat_inc32(stat_correct);
      if (go_recover)           stat_mispredict <= sat_inc32(stat_mispredict);
    end
  end

`ifdef SIMULATION
  final begin
    stats_event("vp_lookup", stat_lookup);
    stats_event("vp_issue", stat_issue);
    stats_event("vp_correct", stat_correct);
    stats_event("vp_mispredict", stat_mispredict);
  end
`endif
`endif

endmodule

// File: tb/tb_load_value_predictor.sv
// Scoreboard bench for load_value_predictor: directed scenarios then random
// traffic, all checked against a queue/array reference model.
module tb_load_value_predictor;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int ENTRIES     = 64;
  localparam int CONF_BITS   = 2;
  localparam int CONF_THRESH = 3;
  localparam int DEPTH       = 4;
  localparam int IDX_W       = $clog2(ENTRIES);
  localparam int CONF_MAX    = (1 << CONF_BITS) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  load_value_predictor_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  load_value_predictor #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .ENTRIES     (ENTRIES),
    .CONF_BITS   (CONF_BITS),
    .CONF_THRESH (CONF_THRESH),
    .DEPTH       (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                  pv;
    logic [DATA_WIDTH-1:0] pval;
    logic                  mp;
    logic                  rr;
    logic                  oe;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  // Reference model: the predictor table as plain arrays, in-flight predictions as a queue.
  bit                    m_valid [ENTRIES];
  logic [ADDR_WIDTH-1:0] m_tag   [ENTRIES];
  logic [DATA_WIDTH-1:0] m_value [ENTRIES];
  int                    m_conf  [ENTRIES];
  logic [DATA_WIDTH-1:0] m_q[$];
  bit                    m_rec;
  bit                    m_ovf;

  task automatic check_bit(input string name, input logic actual, input logic expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_value[i] = '0;
      m_conf[i]  = 0;
    end
    m_q.delete();
    m_rec = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input bit lv, input logic [31:0] lpc, input bit rv,
                            input logic [31:0] rpc, input logic [31:0] rd,
                            input bit rp, input bit fl, input bit rdone, output exp_t e);
    int li, ri, qlen;
    logic [ADDR_WIDTH-1:0] lt, rt;
    bit popped, bad;
    logic [DATA_WIDTH-1:0] h;
    li = int'(lpc >> 2) % ENTRIES;
    ri = int'(rpc >> 2) % ENTRIES;
    lt = lpc >> (2 + IDX_W);
    rt = rpc >> (2 + IDX_W);
    e.pv = 1'b0; e.pval = '0; e.mp = 1'b0;
    qlen = m_q.size();
    popped = 1'b0;
    bad = 1'b0;
    if (rv && rp && !fl) begin
      if (qlen == 0) m_ovf = 1'b1;
      else begin
        h = m_q.pop_front();
        popped = 1'b1;
        bad = (h != rd);
      end
    end
    if (lv && m_valid[li] && m_tag[li] == lt && m_conf[li] >= CONF_THRESH &&
        (qlen < DEPTH || popped) && !m_rec && !fl) begin
      e.pv = 1'b1;
      e.pval = m_value[li];
      m_q.push_back(m_value[li]);
    end
    if (fl || (bad && !m_rec)) m_q.delete();
    if (bad && !m_rec) begin
      e.mp = 1'b1;
      m_rec = 1'b1;
    end else if (m_rec && rdone) begin
      m_rec = 1'b0;
    end
    if (rv) begin
      if (m_valid[ri] && m_tag[ri] == rt && m_value[ri] == rd) begin
        if (m_conf[ri] < CONF_MAX) m_conf[ri]++;
      end else begin
        m_valid[ri] = 1'b1;
        m_tag[ri]   = rt;
        m_value[ri] = rd;
        m_conf[ri]  = 0;
      end
    end
    e.rr = m_rec;
    e.oe = m_ovf;
  endtask

  task automatic apply_stimulus(input bit r, input bit lv, input logic [31:0] lpc,
                                input bit rv, input logic [31:0] rpc, input logic [31:0] rd,
                                input bit rp, input bit fl, input bit rdone);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.lookup_valid  = lv;
    bus.lookup_pc     = lpc;
    bus.res_valid     = rv;
    bus.res_pc        = rpc;
    bus.res_data      = rd;
    bus.res_predicted = rp;
    bus.flush         = fl;
    bus.recovery_done = rdone;
    if (r) begin
      model_reset();
      e.pv = 1'b0; e.pval = '0; e.mp = 1'b0; e.rr = 1'b0; e.oe = 1'b0;
    end else begin
      model_step(lv, lpc, rv, rpc, rd, rp, fl, rdone, e);
    end
    exp_q.push_back(e);
  endtask

  task automatic do_idle();
    apply_stimulus(0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    apply_stimulus(0, 1, pc, 0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic do_resolve(input logic [31:0] pc, input logic [31:0] data, input bit pred);
    apply_stimulus(0, 0, 32'h0, 1, pc, data, pred, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_bit("pred_valid", bus.pred_valid, e.pv);
        if (e.pv) check_output("pred_value", bus.pred_value, e.pval);
        check_bit("mispredict", bus.mispredict, e.mp);
        check_bit("recover_req", bus.recover_req, e.rr);
        check_bit("overflow_err", bus.overflow_err, e.oe);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    logic [31:0] pcs [5];
    logic [31:0] lpc, rpc, rd;
    bit r, lv, rv, rp, fl, rdone;
    pcs[0] = 32'h400; pcs[1] = 32'h404; pcs[2] = 32'h408;
    pcs[3] = 32'h400 + 4 * ENTRIES; pcs[4] = 32'h40C;

    bus.lookup_valid = 0; bus.lookup_pc = '0; bus.res_valid = 0; bus.res_pc = '0;
    bus.res_data = '0; bus.res_predicted = 0; bus.flush = 0; bus.recovery_done = 0;
    model_reset();

    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 32'h400, 1, 32'h400, 32'h1, 1, 1, 0);
    settle();
    check_bit("reset_pred_valid", bus.pred_valid, 1'b0);
    check_bit("reset_overflow", bus.overflow_err, 1'b0);

    // Training: allocation starts at conf 0, so three resolves leave conf 2.
    repeat (3) do_resolve(32'h400, 32'hDEAD, 0);
    do_lookup(32'h400);
    settle();
    check_bit("conf2_no_issue", bus.pred_valid, 1'b0);
    do_resolve(32'h400, 32'hDEAD, 0);
    do_lookup(32'h400);
    settle();
    check_bit("trained_issue", bus.pred_valid, 1'b1);
    check_output("trained_value", bus.pred_value, 32'hDEAD);

    // Mismatch and recovery handshake.
    do_resolve(32'h400, 32'hBEEF, 1);
    settle();
    check_bit("mismatch_pulse", bus.mispredict, 1'b1);
    check_bit("mismatch_recover", bus.recover_req, 1'b1);
    repeat (2) do_idle();
    do_lookup(32'h400);
    settle();
    check_bit("recover_no_issue", bus.pred_valid, 1'b0);
    check_bit("recover_held", bus.recover_req, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    check_bit("recover_released", bus.recover_req, 1'b0);
    do_lookup(32'h400);
    settle();
    check_bit("retrained_no_issue", bus.pred_valid, 1'b0);

    // Queue full, then simultaneous push and pop.
    repeat (4) do_resolve(32'h404, 32'h1111, 0);
    repeat (4) do_lookup(32'h404);
    do_lookup(32'h404);
    settle();
    check_bit("full_blocks_issue", bus.pred_valid, 1'b0);
    apply_stimulus(0, 1, 32'h404, 1, 32'h404, 32'h1111, 1, 0, 0);
    settle();
    check_bit("full_push_pop_issue", bus.pred_valid, 1'b1);
    check_bit("full_push_pop_ok", bus.mispredict, 1'b0);

    // Flush with a wrong predicted resolve: no mispredict, table still trained.
    apply_stimulus(0, 0, 0, 1, 32'h404, 32'h2222, 1, 1, 0);
    settle();
    check_bit("flush_no_mispredict", bus.mispredict, 1'b0);
    do_lookup(32'h404);
    settle();
    check_bit("flush_table_updated", bus.pred_valid, 1'b0);
    do_resolve(32'h404, 32'h2222, 1);
    settle();
    check_bit("empty_resolve_overflow", bus.overflow_err, 1'b1);

    // Aliasing: same index, different tag.
    repeat (3) do_resolve(32'h400, 32'hBEEF, 0);
    do_lookup(32'h400 + 4 * ENTRIES);
    settle();
    check_bit("alias_miss", bus.pred_valid, 1'b0);
    do_lookup(32'h400);
    settle();
    check_output("alias_owner_value", bus.pred_value, 32'hBEEF);
    do_resolve(32'h400, 32'hBEEF, 1);
    settle();
    check_bit("correct_no_mispredict", bus.mispredict, 1'b0);
    check_bit("overflow_sticky", bus.overflow_err, 1'b1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check_bit("overflow_cleared", bus.overflow_err, 1'b0);

    // Randomised traffic, including occasional resets mid-recovery.
    for (int c = 0; c < 3000; c++) begin
      r     = ($urandom_range(0, 399) == 0);
      lv    = $urandom_range(0, 1) == 1;
      lpc   = pcs[$urandom_range(0, 4)];
      rv    = $urandom_range(0, 1) == 1;
      rpc   = pcs[$urandom_range(0, 4)];
      rd    = ($urandom_range(0, 7) == 0) ? (32'hBAD0_0000 | rpc) : (32'hC0DE_0000 | rpc);
      rp    = rv && ((m_q.size() > 0) ? ($urandom_range(0, 3) != 0)
                                      : ($urandom_range(0, 99) == 0));
      fl    = ($urandom_range(0, 39) == 0);
      rdone = m_rec && ($urandom_range(0, 3) == 0);
      apply_stimulus(r, lv, lpc, rv, rpc, rd, rp, fl, rdone);
    end

    do_idle();
    repeat (2) @(posedge clk);
    #2;
    check_output("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
